// File: rtl/cell_streamer.sv
`default_nettype none
// ====================================================================
// cell_streamer : serialises packed grid rows onto the shredder din
//                 line, framing each row with a dead pad cell each side.
// Revision      : 1.0
// ====================================================================
module cell_streamer #(
  parameter int WORD_W    = 8,
  parameter int ROW_WORDS = 2,
  parameter int NUM_ROWS  = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [WORD_W-1:0]   word_in,
  input  logic                word_valid,
  output logic                word_ready,
  output logic                dout,
  output logic                dout_valid,
  output logic                row_start,
  output logic                row_end,
  output logic [((NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1)-1:0] row_idx,
  output logic                busy,
  output logic                done
);

  localparam int BIT_W  = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam int WCNT_W = $clog2(ROW_WORDS + 1);
  localparam int ROW_W  = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;

  localparam logic [BIT_W-1:0]  c_last_bit  = BIT_W'(WORD_W - 1);
  localparam logic [WCNT_W-1:0] c_row_words = WCNT_W'(ROW_WORDS);
  localparam logic [ROW_W-1:0]  c_last_row  = ROW_W'(NUM_ROWS - 1);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PRE_PAD  = 3'd1,
    ST_SHIFT    = 3'd2,
    ST_POST_PAD = 3'd3,
    ST_DONE     = 3'd4
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [WORD_W-1:0]   r_buf, w_buf_nxt;
  logic                r_full, w_full_nxt;
  logic [BIT_W-1:0]    r_bit_cnt, w_bit_nxt;
  logic [WCNT_W-1:0]   r_word_cnt, w_wcnt_nxt;
  logic [ROW_W-1:0]    r_row_idx, w_row_nxt;
  logic                r_dout, r_dout_valid, r_row_start, r_row_end, r_busy, r_done;
  logic                w_last_bit, w_ready, w_load, w_emit_nxt;

  // word_cnt counts words loaded this row, so the final word's last-bit
  // cycle cannot pull in a word belonging to the next row.
  always_comb begin
    w_state_nxt = r_state;
    w_buf_nxt   = r_buf;
    w_full_nxt  = r_full;
    w_bit_nxt   = r_bit_cnt;
    w_wcnt_nxt  = r_word_cnt;
    w_row_nxt   = r_row_idx;
    w_last_bit  = r_full && (r_bit_cnt == c_last_bit);
    w_ready     = ((r_state == ST_PRE_PAD) || (r_state == ST_SHIFT)) &&
                  (r_word_cnt < c_row_words) && (!r_full || w_last_bit);
    w_load      = w_ready && word_valid;

    case (r_state)
      ST_IDLE: begin
        if (start) w_state_nxt = ST_PRE_PAD;
      end
      ST_PRE_PAD: begin
        w_state_nxt = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (w_last_bit && (r_word_cnt == c_row_words)) w_state_nxt = ST_POST_PAD;
      end
      ST_POST_PAD: begin
        w_wcnt_nxt = '0;
        w_full_nxt = 1'b0;
        w_bit_nxt  = '0;
        if (r_row_idx < c_last_row) begin
          w_row_nxt   = r_row_idx + ROW_W'(1);
          w_state_nxt = ST_PRE_PAD;
        end else begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        w_row_nxt   = '0;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    if ((r_state == ST_PRE_PAD) || (r_state == ST_SHIFT)) begin
      if (r_full) begin
        if (w_last_bit) begin
          w_bit_nxt  = '0;
          w_full_nxt = 1'b0;
        end else begin
          w_bit_nxt = r_bit_cnt + BIT_W'(1);
          w_buf_nxt = r_buf >> 1;
        end
      end
      if (w_load) begin
        w_buf_nxt  = word_in;
        w_full_nxt = 1'b1;
        w_bit_nxt  = '0;
        w_wcnt_nxt = r_word_cnt + WCNT_W'(1);
      end
    end

    w_emit_nxt = (w_state_nxt == ST_SHIFT) && w_full_nxt;
  end

  // Output flops are loaded from next-state values so they line up with
  // the state they describe rather than lagging it by a cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_buf        <= '0;
      r_full       <= 1'b0;
      r_bit_cnt    <= '0;
      r_word_cnt   <= '0;
      r_row_idx    <= '0;
      r_dout       <= 1'b0;
      r_dout_valid <= 1'b0;
      r_row_start  <= 1'b0;
      r_row_end    <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_buf        <= w_buf_nxt;
      r_full       <= w_full_nxt;
      r_bit_cnt    <= w_bit_nxt;
      r_word_cnt   <= w_wcnt_nxt;
      r_row_idx    <= w_row_nxt;
      r_dout       <= w_emit_nxt && w_buf_nxt[0];
      r_dout_valid <= w_emit_nxt || (w_state_nxt == ST_PRE_PAD) ||
                      (w_state_nxt == ST_POST_PAD);
      r_row_start  <= (w_state_nxt == ST_PRE_PAD);
      r_row_end    <= (w_state_nxt == ST_POST_PAD);
      r_busy       <= (w_state_nxt != ST_IDLE);
      r_done       <= (w_state_nxt == ST_DONE);
    end
  end

  assign word_ready = w_ready;
  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;
  assign row_start  = r_row_start;
  assign row_end    = r_row_end;
  assign row_idx    = r_row_idx;
  assign busy       = r_busy;
  assign done       = r_done;

endmodule
`default_nettype wire
